// File: rtl/line_drawer.sv
// Bresenham line rasteriser feeding VGA_framebuffer. It makes one pixel write per
// enabled step, covers all octants without swapping endpoints, and clips writes that fall off-screen.
module line_drawer #(
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int X_MAX = 640,
    parameter int Y_MAX = 480
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           step_en,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  logic           color_in,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pixel_color,
    output logic           pixel_write
);
    localparam int ERR_W = X_W + 2;
    localparam int E2_W  = X_W + 3;
    localparam int CX_W  = X_W + 1;
    localparam int CY_W  = Y_W + 1;

    localparam logic signed [CX_W-1:0] X_LIM = CX_W'(X_MAX);
    localparam logic signed [CY_W-1:0] Y_LIM = CY_W'(Y_MAX);
    localparam logic signed [CX_W-1:0] X_ONE = CX_W'(1);
    localparam logic signed [CY_W-1:0] Y_ONE = CY_W'(1);

    typedef enum logic [1:0] {IDLE, INIT, DRAW} state_t;
    state_t state, state_next;

    logic [X_W-1:0]           x0_r, x1_r;
    logic [Y_W-1:0]           y0_r, y1_r;
    logic                     color_r;
    logic                     x_neg, y_neg;
    logic signed [ERR_W-1:0]  dx, dy, err;
    logic signed [CX_W-1:0]   cx;
    logic signed [CY_W-1:0]   cy;

    logic                     x_fwd, y_fwd;
    logic signed [ERR_W-1:0]  dx_init, dy_init, err_next;
    logic signed [E2_W-1:0]   e2, dx_e, dy_e;
    logic signed [CX_W-1:0]   cx_next, x1_ext;
    logic signed [CY_W-1:0]   cy_next, y1_ext;
    logic                     step_x, step_y, at_end, in_range;
    logic                     do_step, last_step;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = INIT;
            INIT:    state_next = DRAW;
            DRAW:    if (step_en && at_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        do_step   = (state == DRAW) && step_en;
        last_step = do_step && at_end;
    end

    always_comb begin
        x_fwd   = x0_r < x1_r;
        y_fwd   = y0_r < y1_r;
        dx_init = x_fwd ? ERR_W'(x1_r - x0_r) : ERR_W'(x0_r - x1_r);
        dy_init = -(y_fwd ? ERR_W'(y1_r - y0_r) : ERR_W'(y0_r - y1_r));

        e2     = {err, 1'b0};
        dx_e   = E2_W'(dx);
        dy_e   = E2_W'(dy);
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);

        // NOTE: blocking '=' is right in combinational logic; err_next accumulates both corrections in order.
        err_next = err;
        cx_next  = cx;
        cy_next  = cy;
        if (step_x) begin
            err_next = err_next + dy;
            cx_next  = x_neg ? cx - X_ONE : cx + X_ONE;
        end
        if (step_y) begin
            err_next = err_next + dx;
            cy_next  = y_neg ? cy - Y_ONE : cy + Y_ONE;
        end

        x1_ext   = {1'b0, x1_r};
        y1_ext   = {1'b0, y1_r};
        at_end   = (cx == x1_ext) && (cy == y1_ext);
        in_range = (cx < X_LIM) && (cy < Y_LIM);
    end

    // NOTE: working registers carry no reset; IDLE and INIT always reload them before DRAW reads them.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                x0_r    <= x0;
                y0_r    <= y0;
                x1_r    <= x1;
                y1_r    <= y1;
                color_r <= color_in;
            end
            INIT: begin
                dx    <= dx_init;
                dy    <= dy_init;
                err   <= dx_init + dy_init;
                x_neg <= !x_fwd;
                y_neg <= !y_fwd;
                cx    <= {1'b0, x0_r};
                cy    <= {1'b0, y0_r};
            end
            DRAW: if (do_step && !at_end) begin
                err <= err_next;
                cx  <= cx_next;
                cy  <= cy_next;
            end
            default: ;
        endcase
    end

    // A clipped step still moves x/y; only the strobe is withheld.
    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            pixel_color <= 1'b0;
            pixel_write <= 1'b0;
            done        <= 1'b0;
        end else begin
            pixel_write <= do_step && in_range;
            done        <= last_step;
            if (do_step) begin
                x           <= cx[X_W-1:0];
                y           <= cy[Y_W-1:0];
                pixel_color <= color_r;
            end
        end
    end

endmodule
